chunk_adder: RTL

CHUNK_ADDER -- requirements
Module: chunk_adder

---
 rtl/chunk_adder_if.sv | 28 ++
 rtl/chunk_adder.sv | 109 ++++++++++
 2 files changed

// File: rtl/chunk_adder_if.sv
// Handshake bundle for chunk_adder: operand request (valid/ready,
// A, B, cin, sub, flush) and result delivery (valid/ready, S, C, V).
interface chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C;
    logic             V;

    modport master (
        output in_valid, A, B, cin, sub, flush, out_ready,
        input  in_ready, out_valid, S, C, V
    );

    modport slave (
        input  in_valid, A, B, cin, sub, flush, out_ready,
        output in_ready, out_valid, S, C, V
    );
endinterface

// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, NCH cycles.
// Ports: clk, rst_n (async low), bus (chunk_adder_if.slave).
module chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic         clk,
    input logic         rst_n,
    chunk_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [KW-1:0] LAST = KW'(NCH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_s;
    logic             r_v;

    logic             w_idle;
    logic             w_run;
    logic             w_done;
    logic             w_last;
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK:0]   w_sum;
    logic             w_v;

    assign w_idle = (r_state == IDLE);
    assign w_run  = (r_state == RUN);
    assign w_done = (r_state == DONE);
    assign w_last = (r_k == LAST);

    always_comb begin
        w_a_ch = '0;
        w_b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_k == KW'(i)) begin
                w_a_ch = r_a[i*CHUNK +: CHUNK];
                w_b_ch = r_b[i*CHUNK +: CHUNK];
            end
        end
        w_sum = {1'b0, w_a_ch} + {1'b0, w_b_ch}
              + {{CHUNK{1'b0}}, r_carry};
    end

    // Sign of S comes from the top bit of the final chunk sum.
    assign w_v = (r_a[WIDTH-1] == r_b[WIDTH-1])
              && (w_sum[CHUNK-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_s     <= '0;
            r_v     <= 1'b0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            unique case (1'b1)
                w_idle: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.A;
                        r_b     <= bus.sub ? ~bus.B : bus.B;
                        r_carry <= bus.sub | bus.cin;
                        r_k     <= '0;
                        r_state <= RUN;
                    end
                end
                w_run: begin
                    for (int i = 0; i < NCH; i++) begin
                        if (r_k == KW'(i)) begin
                            r_s[i*CHUNK +: CHUNK] <= w_sum[CHUNK-1:0];
                        end
                    end
                    r_carry <= w_sum[CHUNK];
                    r_k     <= r_k + KW'(1);
                    if (w_last) begin
                        r_v     <= w_v;
                        r_state <= DONE;
                    end
                end
                w_done: begin
                    if (bus.out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_idle;
    assign bus.out_valid = w_done;
    assign bus.S         = r_s;
    assign bus.C         = r_carry;
    assign bus.V         = r_v;
endmodule
